// File: rtl/riscv_control_fsm_if.sv
// Control/status bundle between the RV32I multi-cycle sequencer and its datapath.
// The master side is the control FSM; the slave side is the datapath/memories.
interface riscv_control_fsm_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        rom_read;
  logic        ram_read;
  logic        ram_write;
  logic        rb_wren;
  logic [2:0]  alu_control;
  logic [4:0]  rs_1;
  logic [4:0]  rs_2;
  logic [4:0]  rd_0;
  logic        alu_bsel;
  logic [31:0] imm;
  logic        wb_sel;
  logic        pc_en;
  logic        pc_sel;
  logic        illegal;

  modport master (
    input  instr, alu_zero,
    output rom_read, ram_read, ram_write, rb_wren, alu_control, rs_1, rs_2, rd_0,
           alu_bsel, imm, wb_sel, pc_en, pc_sel, illegal
  );

  modport slave (
    output instr, alu_zero,
    input  rom_read, ram_read, ram_write, rb_wren, alu_control, rs_1, rs_2, rd_0,
           alu_bsel, imm, wb_sel, pc_en, pc_sel, illegal
  );
endinterface

// File: rtl/riscv_control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, writeback.
// Holds the instruction register; all decode outputs are derived combinationally from it.
module riscv_control_fsm #(
  parameter int MEM_LAT         = 1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_control_fsm_if.master bus
);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [2:0] LAST  = 3'(MEM_LAT - 1);

  typedef enum logic [2:0] {FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ill_q, ill_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic        is_r, is_i, is_lw, is_sw, is_br, bad, br_taken;
  logic [2:0]  alu_op;
  logic [31:0] imm_c;
  logic        rom_c, ramr_c, ramw_c, rbw_c, pcen_c, pcsel_c;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign f7b5   = ir_q[30];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_br  = (opcode == OP_BR);
  assign br_taken = funct3[0] ? ~bus.alu_zero : bus.alu_zero;

  always_comb begin
    alu_op = 3'b000;
    case (funct3)
      3'b000:  alu_op = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b111:  alu_op = 3'b010;
      3'b110:  alu_op = 3'b011;
      3'b100:  alu_op = 3'b100;
      3'b010:  alu_op = 3'b101;
      3'b001:  alu_op = 3'b110;
      3'b101:  alu_op = 3'b111;
      default: alu_op = 3'b000;
    endcase
    if (is_lw || is_sw) alu_op = 3'b000;
    if (is_br)          alu_op = 3'b001;

    // funct7[5] is only meaningful for R-type and the I-type shift encodings
    bad = !(is_r || is_i || is_lw || is_sw || is_br);
    if ((is_r || is_i) && funct3 == 3'b011)                       bad = 1'b1;
    if (is_r && f7b5 && funct3 != 3'b000)                          bad = 1'b1;
    if (is_i && f7b5 && (funct3 == 3'b001 || funct3 == 3'b101))    bad = 1'b1;
    if (is_br && funct3[2:1] != 2'b00)                             bad = 1'b1;
    if ((is_lw || is_sw) && funct3 != 3'b010)                      bad = 1'b1;
  end

  always_comb begin
    imm_c = 32'd0;
    if (is_i || is_lw) imm_c = {{20{ir_q[31]}}, ir_q[31:20]};
    else if (is_sw)    imm_c = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (is_br)    imm_c = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= 32'd0;
      cnt_q   <= 3'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = 3'd0;
    ill_d   = ill_q;
    rom_c   = 1'b0;
    ramr_c  = 1'b0;
    ramw_c  = 1'b0;
    rbw_c   = 1'b0;
    pcen_c  = 1'b0;
    pcsel_c = 1'b0;
    case (state_q)
      FETCH: begin
        rom_c   = 1'b1;
        state_d = FWAIT;
      end
      FWAIT: begin
        if (cnt_q == LAST) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DECODE: begin
        if (bad) begin
          ill_d   = 1'b1;
          state_d = HALT_ON_ILLEGAL ? HALT : EXEC;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        // an illegal instruction only reaches here when it is retired as a NOP
        if (bad) begin
          pcen_c  = 1'b1;
          state_d = FETCH;
        end else if (is_br) begin
          pcen_c  = 1'b1;
          pcsel_c = br_taken;
          state_d = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (is_lw) begin
          ramr_c  = 1'b1;
          state_d = MWAIT;
        end else begin
          ramw_c  = 1'b1;
          pcen_c  = 1'b1;
          state_d = FETCH;
        end
      end
      MWAIT: begin
        if (cnt_q == LAST) state_d = WB;
        else               cnt_d   = cnt_q + 3'd1;
      end
      WB: begin
        rbw_c   = (ir_q[11:7] != 5'd0);
        pcen_c  = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // FETCH is the reset state, so its strobe is masked while reset is held
  assign bus.rom_read    = rom_c & rst_n;
  assign bus.ram_read    = ramr_c;
  assign bus.ram_write   = ramw_c;
  assign bus.rb_wren     = rbw_c;
  assign bus.pc_en       = pcen_c;
  assign bus.pc_sel      = pcsel_c;
  assign bus.illegal     = ill_q;
  assign bus.alu_control = alu_op;
  assign bus.rs_1        = ir_q[19:15];
  assign bus.rs_2        = ir_q[24:20];
  assign bus.rd_0        = ir_q[11:7];
  assign bus.alu_bsel    = is_i | is_lw | is_sw;
  assign bus.imm         = imm_c;
  assign bus.wb_sel      = is_lw;
endmodule
